// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut into STAGES
// registered slices of CHUNK bits; flags are derived from the final slice.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;

    function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] a,
                                              input logic [CHUNK-1:0] b,
                                              input logic             ci);
        logic [CHUNK:0] r;
        logic           c;
        r = '0;
        c = ci;
        for (int i = 0; i < CHUNK; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[CHUNK] = c;
        return r;
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_op;
    logic             carry0;

    // Index k is the input side of stage k; index STAGES is the pipe output.
    logic [STAGES:0]  vld_pipe;
    logic [STAGES:0]  carry_pipe;
    logic [STAGES:0]  a_msb_pipe;
    logic [STAGES:0]  b_msb_pipe;

    always_comb begin
        en     = !out_valid || out_ready;
        b_op   = sub ? ~B : B;
        carry0 = sub ? 1'b1 : c_in;
    end

    assign in_ready      = en;
    assign vld_pipe[0]   = in_valid;
    assign carry_pipe[0] = carry0;
    assign a_msb_pipe[0] = A[WIDTH-1];
    assign b_msb_pipe[0] = b_op[WIDTH-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO   = k * CHUNK;
        localparam int HI_W = WIDTH - LO;

        logic [HI_W-1:0]     a_src, b_src;
        logic [CHUNK:0]      part;
        logic [LO+CHUNK-1:0] sum_new, sum_d, sum_q;
        logic                vld_d, vld_q;
        logic                co_d, co_q;
        logic                a_msb_d, a_msb_q;
        logic                b_msb_d, b_msb_q;

        assign part = ripple(a_src[CHUNK-1:0], b_src[CHUNK-1:0], carry_pipe[k]);

        if (k == 0) begin : g_head
            assign a_src   = A;
            assign b_src   = b_op;
            assign sum_new = part[CHUNK-1:0];
        end else begin : g_body
            assign a_src   = g_stg[k-1].g_skew.a_hi_q;
            assign b_src   = g_stg[k-1].g_skew.b_hi_q;
            assign sum_new = {part[CHUNK-1:0], g_stg[k-1].sum_q};
        end

        // Operand bits above this slice ride along untouched for later stages.
        if (k < STAGES - 1) begin : g_skew
            logic [HI_W-CHUNK-1:0] a_hi_d, a_hi_q, b_hi_d, b_hi_q;

            always_comb begin
                a_hi_d = en ? a_src[HI_W-1:CHUNK] : a_hi_q;
                b_hi_d = en ? b_src[HI_W-1:CHUNK] : b_hi_q;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end

        always_comb begin
            sum_d   = en ? sum_new       : sum_q;
            co_d    = en ? part[CHUNK]   : co_q;
            vld_d   = en ? vld_pipe[k]   : vld_q;
            a_msb_d = en ? a_msb_pipe[k] : a_msb_q;
            b_msb_d = en ? b_msb_pipe[k] : b_msb_q;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sum_q   <= '0;
                co_q    <= 1'b0;
                vld_q   <= 1'b0;
                a_msb_q <= 1'b0;
                b_msb_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                co_q    <= co_d;
                vld_q   <= vld_d;
                a_msb_q <= a_msb_d;
                b_msb_q <= b_msb_d;
            end
        end

        assign vld_pipe[k+1]   = vld_q;
        assign carry_pipe[k+1] = co_q;
        assign a_msb_pipe[k+1] = a_msb_q;
        assign b_msb_pipe[k+1] = b_msb_q;
    end

    always_comb begin
        out_valid = vld_pipe[STAGES];
        result    = g_stg[STAGES-1].sum_q;
        c_out     = carry_pipe[STAGES];
        overflow  = (a_msb_pipe[STAGES] == b_msb_pipe[STAGES]) &&
                    (result[WIDTH-1] != a_msb_pipe[STAGES]);
        zero      = ~|result;
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: a 4-stage unit under back-pressure and a 1-stage
// unit fed the same accepted stream, both checked against an arithmetic model.
module tb_pipelined_add_sub;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    typedef struct {
        res_t e;
        int   acc;
        bit   stalled;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, sub = 1'b0, c_in = 1'b0, out_ready = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic        in_ready, out_valid, c_out, overflow, zero;
    logic [31:0] result;
    logic        in_valid1, in_ready1, out_valid1, c_out1, overflow1, zero1;
    logic [31:0] result1;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rand_rdy = 0;
    ent_t q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    assign in_valid1 = in_valid && in_ready;

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sub(sub), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .c_out(c_out), .overflow(overflow), .zero(zero)
    );

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A), .B(B), .sub(sub), .c_in(c_in), .out_valid(out_valid1), .out_ready(1'b1),
        .result(result1), .c_out(c_out1), .overflow(overflow1), .zero(zero1)
    );

    // True two's-complement / unsigned arithmetic, independent of any slicing.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic ci);
        res_t        m;
        longint      t;
        logic [32:0] u;
        if (s) begin
            u   = {1'b0, a} - {1'b0, b};
            t   = longint'($signed(a)) - longint'($signed(b));
            m.c = (a >= b);
        end else begin
            u   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            t   = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
            m.c = u[32];
        end
        m.r = u[31:0];
        m.v = (t != longint'($signed(m.r)));
        m.z = (m.r == 32'd0);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ci);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        A = a; B = b; sub = s; c_in = ci; in_valid = 1'b1;
        while (!acc) begin
            @(negedge clock);
            acc = in_ready;
            tick();
            n++;
            if (!acc && n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
                acc = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input res_t exp);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < 20);
        chk(name, {out_valid, result, c_out, overflow, zero}, {1'b1, exp});
        chk({name, "_latency"}, n, 4);
        tick();
    endtask

    initial begin : rdy_drv
        forever begin
            tick();
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : cmp
        res_t snap, p1;
        bit   snap_ok, p1_v;
        ent_t ent;
        snap_ok = 0;
        p1_v    = 0;
        snap    = '0;
        p1      = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                q.delete();
                snap_ok = 0;
                p1_v    = 0;
                chk("rst_out_valid", out_valid, 1'b0);
                chk("rst_out_valid1", out_valid1, 1'b0);
                continue;
            end
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (snap_ok)
                chk("stall_hold", {out_valid, result, c_out, overflow, zero}, {1'b1, snap});
            if (q.size() == 0)
                chk("no_spurious", out_valid, 1'b0);
            else if (!q[0].stalled)
                chk("latency", out_valid, cyc == q[0].acc + STAGES);
            if (out_valid && q.size() > 0) begin
                chk("data", {result, c_out, overflow, zero}, q[0].e);
                if (out_ready) void'(q.pop_front());
            end
            snap_ok = out_valid && !out_ready;
            snap    = {result, c_out, overflow, zero};
            if (snap_ok) foreach (q[i]) q[i].stalled = 1;

            chk("s1_valid", out_valid1, p1_v);
            if (p1_v) chk("s1_data", {result1, c_out1, overflow1, zero1}, p1);
            p1_v = in_valid1;
            if (in_valid && in_ready) begin
                ent.e       = model(A, B, sub, c_in);
                ent.acc     = cyc;
                ent.stalled = 0;
                q.push_back(ent);
                p1 = ent.e;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        chk("pin_ripple",  model(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0), {32'h00000000, 1'b1, 1'b0, 1'b1});
        chk("pin_sub_ov",  model(32'h80000000, 32'h1, 1'b1, 1'b0), {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
        chk("pin_sub_neg", model(32'h3, 32'h5, 1'b1, 1'b0),        {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        chk("pin_cin",     model(32'h7FFFFFFF, 32'h0, 1'b0, 1'b1), {32'h80000000, 1'b0, 1'b1, 1'b0});
        chk("pin_cin_ign", model(32'h7FFFFFFF, 32'h0, 1'b1, 1'b1), {32'h7FFFFFFF, 1'b1, 1'b0, 1'b0});

        #2;
        chk("reset_state", {out_valid, in_ready, result, c_out, overflow, zero},
            {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1});
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
        wait_out("dut_ripple", {32'h00000000, 1'b1, 1'b0, 1'b1});
        send(32'h7FFFFFFF, 32'h0, 1'b0, 1'b1);
        wait_out("dut_cin", {32'h80000000, 1'b0, 1'b1, 1'b0});

        send(32'h80000000, 32'h1, 1'b1, 1'b0);
        send(32'h3, 32'h5, 1'b1, 1'b0);
        send(32'h7FFFFFFF, 32'h0, 1'b1, 1'b1);
        send(32'h0, 32'h80000000, 1'b1, 1'b0);
        send(32'h12345678, 32'h12345678, 1'b1, 1'b1);
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
        repeat (6) tick();

        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ((i % 2) ? 3 : 1) tick();
        end
        repeat (6) tick();

        rand_rdy = 1;
        for (int i = 0; i < 10; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rand_rdy = 0;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", q.size());
        end
        repeat (3) tick();

        for (int i = 0; i < 5; i++)
            send($urandom, $urandom, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {out_valid, in_ready, result, c_out, overflow, zero},
            {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1});
        tick();
        A = 32'hDEADBEEF; B = 32'h1; in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        reset_n  = 1'b1;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
